// File: rtl/countdown_timer.sv
// MM:SS countdown timer with setup editing, pause/resume and a timed buzzer alarm.
// Button inputs are debounced levels; each rising edge is one event.
module countdown_timer #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned ALARM_SEC = 5,
  parameter int unsigned BUZZ_DIV  = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode,
  input  logic       i_pos,
  input  logic       i_inc,
  input  logic       i_start,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [2:0] o_state,
  output logic       o_pos,
  output logic       o_buzz
);

  localparam int unsigned TickW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BuzzW  = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam int unsigned AlarmW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(CLK_HZ - 1);
  localparam logic [BuzzW-1:0]  BuzzLast  = BuzzW'(BUZZ_DIV - 1);
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(ALARM_SEC - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StAlarm = 3'd4
  } state_e;

  state_e            r_state, w_state_d;
  logic [5:0]        r_min, w_min_d;
  logic [5:0]        r_sec, w_sec_d;
  logic              r_pos, w_pos_d;
  logic              r_buzz, w_buzz_d;
  logic [TickW-1:0]  r_tick, w_tick_d;
  logic [BuzzW-1:0]  r_buzz_cnt, w_buzz_cnt_d;
  logic [AlarmW-1:0] r_alarm, w_alarm_d;

  // Button bits ordered {start, mode, pos, inc}
  logic [3:0] r_btn_cur, r_btn_prev;
  logic [3:0] w_rise;
  logic       w_ev_start, w_ev_mode, w_ev_pos, w_ev_inc;
  logic       w_tick_hit, w_nonzero;

  assign w_rise     = r_btn_cur & ~r_btn_prev;
  assign w_ev_start = w_rise[3];
  assign w_ev_mode  = w_rise[2] & ~w_rise[3];
  assign w_ev_pos   = w_rise[1] & ~(|w_rise[3:2]);
  assign w_ev_inc   = w_rise[0] & ~(|w_rise[3:1]);
  assign w_tick_hit = (r_tick == TickLast);
  assign w_nonzero  = (r_min != 6'd0) || (r_sec != 6'd0);

  function automatic logic [5:0] inc_wrap(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    w_state_d    = r_state;
    w_min_d      = r_min;
    w_sec_d      = r_sec;
    w_pos_d      = r_pos;
    w_buzz_d     = r_buzz;
    w_buzz_cnt_d = r_buzz_cnt;
    w_alarm_d    = r_alarm;
    w_tick_d     = '0;
    if (r_state == StRun || r_state == StAlarm) begin
      w_tick_d = w_tick_hit ? '0 : r_tick + TickW'(1);
    end

    case (r_state)
      StIdle: begin
        if (w_ev_start && w_nonzero) w_state_d = StRun;
        else if (w_ev_mode)          w_state_d = StSetup;
      end
      StSetup: begin
        if (w_ev_mode) begin
          w_state_d = StIdle;
        end else if (w_ev_pos) begin
          w_pos_d = ~r_pos;
        end else if (w_ev_inc) begin
          if (r_pos) w_min_d = inc_wrap(r_min);
          else       w_sec_d = inc_wrap(r_sec);
        end
      end
      StRun: begin
        if (w_ev_start) begin
          w_state_d = StPause;
        end else if (w_tick_hit) begin
          // Reaching 00:00 raises the alarm on the same edge
          if (r_min == 6'd0 && r_sec <= 6'd1) begin
            w_sec_d   = 6'd0;
            w_state_d = StAlarm;
          end else if (r_sec != 6'd0) begin
            w_sec_d = r_sec - 6'd1;
          end else begin
            w_sec_d = 6'd59;
            w_min_d = r_min - 6'd1;
          end
        end
      end
      StPause: begin
        if (w_ev_start)     w_state_d = StRun;
        else if (w_ev_mode) w_state_d = StSetup;
      end
      StAlarm: begin
        if (w_ev_start || w_ev_mode) begin
          w_state_d = StIdle;
        end else if (w_tick_hit) begin
          if (r_alarm == AlarmLast) w_state_d = StIdle;
          else                      w_alarm_d = r_alarm + AlarmW'(1);
        end
        if (r_buzz_cnt == BuzzLast) begin
          w_buzz_cnt_d = '0;
          w_buzz_d     = ~r_buzz;
        end else begin
          w_buzz_cnt_d = r_buzz_cnt + BuzzW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Every state change restarts the tick period; alarm bookkeeping lives only in ALARM
    if (w_state_d != r_state) w_tick_d = '0;
    if (w_state_d != StAlarm || r_state != StAlarm) begin
      w_buzz_d     = 1'b0;
      w_buzz_cnt_d = '0;
      w_alarm_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_min      <= 6'd0;
      r_sec      <= 6'd0;
      r_pos      <= 1'b0;
      r_buzz     <= 1'b0;
      r_tick     <= '0;
      r_buzz_cnt <= '0;
      r_alarm    <= '0;
      r_btn_cur  <= 4'b0;
      r_btn_prev <= 4'b0;
    end else begin
      r_state    <= w_state_d;
      r_min      <= w_min_d;
      r_sec      <= w_sec_d;
      r_pos      <= w_pos_d;
      r_buzz     <= w_buzz_d;
      r_tick     <= w_tick_d;
      r_buzz_cnt <= w_buzz_cnt_d;
      r_alarm    <= w_alarm_d;
      r_btn_cur  <= {i_start, i_mode, i_pos, i_inc};
      r_btn_prev <= r_btn_cur;
    end
  end

  assign o_min   = r_min;
  assign o_sec   = r_sec;
  assign o_state = r_state;
  assign o_pos   = r_pos;
  assign o_buzz  = r_buzz;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per 1 s tick.
REQ-002 SHALL have parameter ALARM_SEC, default 5: alarm duration in ticks.
REQ-003 SHALL have parameter BUZZ_DIV, default 25000: clk cycles per o_buzz half-period.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_mode  input  1  debounced level; rising edge toggles setup.
REQ-007 SHALL have port i_pos  input  1  debounced level; rising edge toggles edit field.
REQ-008 SHALL have port i_inc  input  1  debounced level; rising edge increments edit field.
REQ-009 SHALL have port i_start  input  1  debounced level; rising edge starts, pauses or resumes.
REQ-010 SHALL have port o_min  output  6  minutes, 0..59.
REQ-011 SHALL have port o_sec  output  6  seconds, 0..59.
REQ-012 SHALL have port o_state  output  3  state code per REQ-015.
REQ-013 SHALL have port o_pos  output  1  edit field: 0 = sec, 1 = min.
REQ-014 SHALL have port o_buzz  output  1  alarm square wave.

Function
REQ-015 SHALL implement FSM IDLE=0, SETUP=1, RUN=2, PAUSE=3, ALARM=4; o_state is the registered state.
REQ-016 SHALL register each input once and detect rising edges (cur=1, prev=0); an event acts on the clk edge after the edge is first registered; a held level is one event.
REQ-017 SHALL accept at most one event per cycle, priority start > mode > pos > inc; lower-priority events in that cycle are dropped.
REQ-018 IDLE: mode -> SETUP; start with value != 00:00 -> RUN; start at 00:00 -> no effect.
REQ-019 SETUP: pos toggles o_pos; inc adds 1 to the selected field, 59 wraps to 0 with no carry; mode -> IDLE; start ignored.
REQ-020 RUN: start -> PAUSE; mode, pos and inc ignored.
REQ-021 PAUSE: start -> RUN; mode -> SETUP with the value kept; pos and inc ignored.
REQ-022 Tick counter SHALL run only in RUN and ALARM; it is cleared to 0 on every entry to RUN or ALARM; a tick occurs when the count reaches CLK_HZ-1, after which the count returns to 0.
REQ-023 First RUN tick SHALL occur exactly CLK_HZ cycles after RUN entry; a pause/resume restarts the full period.
REQ-024 On a RUN tick: sec>0 -> sec-1; sec=0 and min>0 -> sec=59, min-1.
REQ-025 A RUN tick at 00:01 SHALL produce 00:00 and enter ALARM on the same edge.
REQ-026 ALARM SHALL count ticks and return to IDLE on tick number ALARM_SEC; any start or mode event exits to IDLE at once; the value stays 00:00.
REQ-027 In ALARM, o_buzz SHALL toggle every BUZZ_DIV cycles, starting 0 at entry; o_buzz SHALL be 0 in all other states.
REQ-028 Value SHALL never leave 0..59 per field; no underflow below 00:00.

Reset
REQ-029 rst_n low SHALL force state IDLE, o_min=0, o_sec=0, o_pos=0, o_buzz=0, all counters 0 and edge registers 0, immediately and at any time, including mid-RUN or mid-ALARM.
REQ-030 After rst_n release, an input already high SHALL count as one rising edge.

Verification (CLK_HZ=10, ALARM_SEC=2, BUZZ_DIV=2)
REQ-031 Setup wrap: mode, then 60 inc pulses at pos=0 -> o_sec=0 and o_min=0; 3 more inc -> o_sec=3.
REQ-032 Countdown: set 01:00, mode back to IDLE, start -> 00:59 exactly 10 clks after RUN entry; after 60 ticks -> 00:00 and state=4 on the same edge.
REQ-033 Alarm: o_buzz toggles every 2 clks for 20 clks, then state=0 and o_buzz=0; a separate run with start during ALARM -> IDLE on the next cycle.
REQ-034 Pause: start at 00:05, start again after 25 clks -> value 00:03 held; resume -> 00:02 exactly 10 clks later.
REQ-035 Simultaneous: start and inc rising together in SETUP -> neither applied (start ignored, inc dropped); mode and inc together in SETUP -> IDLE, value unchanged.
REQ-036 Reset: rst_n low mid-RUN at 00:42 -> all outputs 0 and state=0 without waiting for a clk edge; start at 00:00 afterwards -> stays IDLE.
